// File: rtl/instruction_fetch_unit.sv
// Purpose : MIPS fetch front end. Holds the PC, drives instruction memory and fills the IF/ID register.
// Latency : the instruction at PC reaches ifid_* one edge after PC is presented; a redirect costs one bubble.
// Backpressure: i_stall holds PC, IF/ID and the fetch counter; a redirect overrides a stall; HALT ignores stall.
//
// Ports:
//   i_clk, i_reset            clock; asynchronous active-high reset
//   i_stall                   hazard hold request
//   i_redirect_valid/_target  taken branch/jump and its new PC
//   o_imem_address            fetch address (the PC register, no input-to-output path)
//   i_imem_instruction        combinational memory response for o_imem_address
//   o_ifid_instruction/_pc_plus4/_valid   IF/ID pipeline register
//   o_fault, o_fault_pc       HALT indication and the PC that caused it
//   o_fetch_count             number of valid instructions delivered to IF/ID
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_imem_address,
    input  logic [31:0] i_imem_instruction,
    output logic [31:0] o_ifid_instruction,
    output logic [31:0] o_ifid_pc_plus4,
    output logic        o_ifid_valid,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_count
);

    localparam logic [31:0] LP_MAX_PC = 32'(MEM_BYTES - 4);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instruction;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic [31:0] r_fault_pc;
    logic [31:0] r_fetch_count;
    logic        w_pc_fault;
    logic [31:0] w_pc_plus4;

    // Misaligned or beyond the last word; the compare is unsigned over all 32 bits,
    // so wrapped-around addresses near 2^32 also fault.
    assign w_pc_fault = (r_pc[1:0] != 2'b00) || (r_pc > LP_MAX_PC);
    assign w_pc_plus4 = r_pc + 32'd4;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_redirect_valid) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pc_fault) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                // A faulting target is caught by the RUN check on the following edge.
                if (i_redirect_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_fault = (r_state == ST_HALT);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc               <= RESET_PC;
            r_ifid_instruction <= 32'h0;
            r_ifid_pc_plus4    <= 32'h0;
            r_ifid_valid       <= 1'b0;
            r_fault_pc         <= 32'h0;
            r_fetch_count      <= 32'h0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_redirect_valid) begin
                        // No delay slot: whatever was being fetched is squashed.
                        r_pc               <= i_redirect_target;
                        r_ifid_instruction <= 32'h0;
                        r_ifid_pc_plus4    <= 32'h0;
                        r_ifid_valid       <= 1'b0;
                    end else if (w_pc_fault) begin
                        r_fault_pc         <= r_pc;
                        r_ifid_instruction <= 32'h0;
                        r_ifid_pc_plus4    <= 32'h0;
                        r_ifid_valid       <= 1'b0;
                    end else if (!i_stall) begin
                        r_pc               <= w_pc_plus4;
                        r_ifid_instruction <= i_imem_instruction;
                        r_ifid_pc_plus4    <= w_pc_plus4;
                        r_ifid_valid       <= 1'b1;
                        r_fetch_count      <= r_fetch_count + 32'd1;
                    end
                end
                ST_HALT: begin
                    // IF/ID already holds the bubble written on the faulting edge.
                    if (i_redirect_valid) begin
                        r_pc <= i_redirect_target;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_imem_address     = r_pc;
    assign o_ifid_instruction = r_ifid_instruction;
    assign o_ifid_pc_plus4    = r_ifid_pc_plus4;
    assign o_ifid_valid       = r_ifid_valid;
    assign o_fault_pc         = r_fault_pc;
    assign o_fetch_count      = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose : directed scoreboard bench for instruction_fetch_unit.
// Latency : each vector's expectation is checked 1 time unit after the edge it targets.
// Backpressure: stall, redirect and fault cases are driven explicitly in the vector list.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit stim_done = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        vld;
        logic        flt;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(1024)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_imem_address    (imem_address),
        .i_imem_instruction(imem_instruction),
        .o_ifid_instruction(ifid_instruction),
        .o_ifid_pc_plus4   (ifid_pc_plus4),
        .o_ifid_valid      (ifid_valid),
        .o_fault           (fault),
        .o_fault_pc        (fault_pc),
        .o_fetch_count     (fetch_count)
    );

    // Memory: word at byte address a is 32'hC0DE_0000 + a; anything out of range is DEADBEEF.
    always_comb begin
        if (imem_address[1:0] == 2'b00 && imem_address <= 32'd1020)
            imem_instruction = 32'hC0DE_0000 + imem_address;
        else
            imem_instruction = 32'hDEAD_BEEF;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pc"},    imem_address,     32'h0);
        chk({tag, ".ins"},   ifid_instruction, 32'h0);
        chk({tag, ".pp4"},   ifid_pc_plus4,    32'h0);
        chk({tag, ".vld"},   {31'h0, ifid_valid}, 32'h0);
        chk({tag, ".flt"},   {31'h0, fault},      32'h0);
        chk({tag, ".fpc"},   fault_pc,         32'h0);
        chk({tag, ".cnt"},   fetch_count,      32'h0);
    endtask

    // Drive one edge's inputs and queue the state expected right after that edge.
    task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] tgt,
                        input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] pp4,
                        input logic vld, input logic flt, input logic [31:0] fpc,
                        input logic [31:0] cnt);
        exp_t e;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        e.tag = tag; e.pc = pc; e.ins = ins; e.pp4 = pp4;
        e.vld = vld; e.flt = flt; e.fpc = fpc; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".pc"},  imem_address,        e.pc);
                chk({e.tag, ".ins"}, ifid_instruction,    e.ins);
                chk({e.tag, ".pp4"}, ifid_pc_plus4,       e.pp4);
                chk({e.tag, ".vld"}, {31'h0, ifid_valid}, {31'h0, e.vld});
                chk({e.tag, ".flt"}, {31'h0, fault},      {31'h0, e.flt});
                chk({e.tag, ".fpc"}, fault_pc,            e.fpc);
                chk({e.tag, ".cnt"}, fetch_count,         e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        #2;
        check_reset("rst0");
        @(negedge clk);
        reset = 1'b0;

        //    tag     st  rv  target        pc            ins           pp4           v  f  fpc           cnt
        // Sequential fetch with a two-cycle stall while IF/ID holds W1.
        step("seq1",  0, 0, 32'h0,        32'h0000_0004, 32'hC0DE_0000, 32'h0000_0004, 1, 0, 32'h0,        32'd1);
        step("seq2",  0, 0, 32'h0,        32'h0000_0008, 32'hC0DE_0004, 32'h0000_0008, 1, 0, 32'h0,        32'd2);
        step("stl1",  1, 0, 32'h0,        32'h0000_0008, 32'hC0DE_0004, 32'h0000_0008, 1, 0, 32'h0,        32'd2);
        step("stl2",  1, 0, 32'h0,        32'h0000_0008, 32'hC0DE_0004, 32'h0000_0008, 1, 0, 32'h0,        32'd2);
        step("seq3",  0, 0, 32'h0,        32'h0000_000C, 32'hC0DE_0008, 32'h0000_000C, 1, 0, 32'h0,        32'd3);
        step("seq4",  0, 0, 32'h0,        32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1, 0, 32'h0,        32'd4);
        // Redirect wins over a simultaneous stall; exactly one bubble.
        step("rdst",  1, 1, 32'h0000_0040, 32'h0000_0040, 32'h0,       32'h0,         0, 0, 32'h0,        32'd4);
        step("rdtg",  0, 0, 32'h0,        32'h0000_0044, 32'hC0DE_0040, 32'h0000_0044, 1, 0, 32'h0,        32'd5);
        // Walk to the top of memory: 1020 is legal, 1024 faults.
        step("rdhi",  0, 1, 32'd1012,     32'd1012,      32'h0,         32'h0,         0, 0, 32'h0,        32'd5);
        step("hi1",   0, 0, 32'h0,        32'd1016,      32'hC0DE_03F4, 32'd1016,      1, 0, 32'h0,        32'd6);
        step("hi2",   0, 0, 32'h0,        32'd1020,      32'hC0DE_03F8, 32'd1020,      1, 0, 32'h0,        32'd7);
        step("hi3",   0, 0, 32'h0,        32'd1024,      32'hC0DE_03FC, 32'd1024,      1, 0, 32'h0,        32'd8);
        step("rflt",  0, 0, 32'h0,        32'd1024,      32'h0,         32'h0,         0, 1, 32'd1024,     32'd8);
        step("hstl",  1, 0, 32'h0,        32'd1024,      32'h0,         32'h0,         0, 1, 32'd1024,     32'd8);
        // Misaligned target from HALT: leave HALT, then re-fault one edge later.
        step("mis1",  0, 1, 32'h0000_0022, 32'h0000_0022, 32'h0,       32'h0,         0, 0, 32'd1024,     32'd8);
        step("mis2",  0, 0, 32'h0,        32'h0000_0022, 32'h0,         32'h0,         0, 1, 32'h0000_0022, 32'd8);
        step("rec1",  0, 1, 32'h0000_0010, 32'h0000_0010, 32'h0,       32'h0,         0, 0, 32'h0000_0022, 32'd8);
        step("rec2",  0, 0, 32'h0,        32'h0000_0014, 32'hC0DE_0010, 32'h0000_0014, 1, 0, 32'h0000_0022, 32'd9);
        // A wrapped-looking address near 2^32 faults on the unsigned range check.
        step("top1",  0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,         0, 0, 32'h0000_0022, 32'd9);
        step("top2",  0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,         32'h0,         0, 1, 32'hFFFF_FFFC, 32'd9);

        // Reset pulse between edges while in HALT.
        reset = 1'b1;
        #1;
        check_reset("rsth");
        #1;
        reset = 1'b0;
        step("rst1",  0, 0, 32'h0,        32'h0000_0004, 32'hC0DE_0000, 32'h0000_0004, 1, 0, 32'h0,        32'd1);
        step("rst2",  0, 0, 32'h0,        32'h0000_0008, 32'hC0DE_0004, 32'h0000_0008, 1, 0, 32'h0,        32'd2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the pipelined MIPS that drives the instruction memory. It holds the program counter and presents it as the fetch address. It captures the returned big-endian word into the IF/ID pipeline register and handles hazard stalls, branch/jump redirects and fetch faults. The byte-addressed instruction memory answers combinationally; this block owns all sequencing.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MEM_BYTES`, 1024, instruction memory size in bytes; the highest legal fetch PC is `MEM_BYTES-4`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `redirect_valid`  in  1  taken branch/jump resolved this cycle.
- `redirect_target`  in  32  new PC when `redirect_valid`=1.
- `imem_address`  out  32  byte address to instruction memory; equals PC.
- `imem_instruction`  in  32  word returned combinationally for `imem_address`.
- `ifid_instruction`  out  32  IF/ID instruction.
- `ifid_pc_plus4`  out  32  IF/ID PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `fault`  out  1  high while in HALT state.
- `fault_pc`  out  32  PC that caused the fault.
- `fetch_count`  out  32  number of instructions delivered with `ifid_valid`=1.

## Operation
- Two-state FSM: RUN, HALT. Reset enters RUN.
- Fault check, combinational on PC: faulting if PC[1:0]≠0 or PC > MEM_BYTES-4.
- In RUN, per-edge priority: redirect > fault > stall > normal.
  - **redirect_valid=1:** PC←redirect_target; IF/ID←bubble (instruction 0, pc_plus4 0, valid 0). Applies even when stall=1. No delay slot.
  - **Faulting PC:** state←HALT; fault_pc←PC; IF/ID←bubble; PC holds.
  - **stall=1:** PC, IF/ID and fetch_count all hold.
  - **Normal:** IF/ID←{imem_instruction, PC+4, valid 1}; PC←PC+4; fetch_count←fetch_count+1.
- In HALT:
  - PC, fault_pc and fetch_count hold; IF/ID keeps its bubble; stall is ignored.
  - redirect_valid=1 → PC←target, state←RUN, fault_pc unchanged.
  - A faulting target re-enters HALT one edge later and updates fault_pc.
- Arithmetic:
  - PC+4 is modulo 2^32.
  - The range check is an unsigned compare on the full 32-bit PC.
  - fetch_count wraps 2^32-1→0.
- An invalid (bubble) instruction is 32'h0 (sll $0,$0,0) so downstream decode treats it as a NOP even if valid is ignored.

## Timing
- Reset values:
  - PC=RESET_PC, so imem_address=RESET_PC immediately.
  - ifid_instruction=0, ifid_pc_plus4=0, ifid_valid=0.
  - fault=0, fault_pc=0, fetch_count=0, state RUN.
- Reset asserted mid-operation, including in HALT, forces all of the above asynchronously. The first fetch is captured on the first rising edge with reset low.
- Latency: instruction at PC appears on ifid_* one edge after PC is presented. Throughput is one instruction per cycle when not stalled.
- Redirect: the target drives imem_address the cycle after the redirect edge. The target instruction reaches IF/ID one further edge later, giving exactly one bubble.
- Fault: fault rises on the edge after the faulting PC is presented.
- imem_address is a direct wire from the PC register; there is no combinational path from inputs to imem_address.

## Test plan
- **Sequential fetch:** reset, memory words W0..W3 at 0,4,8,12, no stall → ifid_instruction = W0,W1,W2,W3 on edges 1-4; ifid_pc_plus4 = 4,8,12,16; fetch_count=4.
- **Stall:** stall=1 for 2 cycles while IF/ID holds W1 (PC=8) → ifid, PC and count unchanged for 2 edges. W2 appears on the first edge after stall drops.
- **Redirect with simultaneous stall:** redirect_valid=1, target=0x40, stall=1 → next edge: PC=0x40, ifid_valid=0. Following edge: ifid_instruction=mem[0x40], ifid_pc_plus4=0x44.
- **Range fault:** run sequentially to PC=1020, then 1024 → W@1020 is delivered; on the next edge fault=1, fault_pc=1024, ifid_valid=0, PC stays 1024.
- **Misaligned redirect and recovery:** redirect target 0x22 → fault=1, fault_pc=0x22 one edge later. Then redirect target 0x10 → fault=0 and PC=0x10; mem[0x10] is captured the following edge.
- **Reset in HALT:** while fault=1, pulse reset between edges → all outputs return to their reset values immediately; fetching restarts at RESET_PC.
